// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM read and write paths.
// Widths, the timer width and the write-side state type are all defined here.
package sram_pkg;

    localparam int SRAM_ADDR_W  = 16;
    localparam int SRAM_DATA_W  = 32;
    localparam int SRAM_TIMER_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        WRITE,
        DONE
    } sram_wr_state_t;

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable 4-bit down-counter used to count SRAM wait states.
// It saturates at zero, and a load takes priority over a decrement.
module sram_wait_timer
    import sram_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    load,
    input  logic [SRAM_TIMER_W-1:0] load_val,
    input  logic                    dec,
    output logic [SRAM_TIMER_W-1:0] value,
    output logic                    zero
);

    logic [SRAM_TIMER_W-1:0] value_q;
    logic [SRAM_TIMER_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/sram_write.sv
// SRAM burst write controller. Each accepted word is held on address/write_data
// with write asserted for SRAM_WAIT cycles; done pulses once when the burst ends.
module sram_write
    import sram_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int SRAM_WAIT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              wvalid,
    output logic              wready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              write,
    output logic              busy,
    output logic              done
);

    sram_wr_state_t state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              write_q, write_d;
    logic              done_q, done_d;

    logic                    timer_load;
    logic                    timer_dec;
    logic [SRAM_TIMER_W-1:0] timer_val;
    logic                    timer_zero;

    sram_wait_timer u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (timer_load),
        .load_val (SRAM_TIMER_W'(SRAM_WAIT - 1)),
        .dec      (timer_dec),
        .value    (timer_val),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        remaining_d  = remaining_q;
        write_data_d = write_data_q;
        write_d      = write_q;
        done_d       = 1'b0;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        address_d   = start_addr;
                        remaining_d = word_count;
                        state_d     = WAIT_DATA;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAIT_DATA: begin
                if (wvalid) begin
                    write_data_d = wdata_in;
                    timer_load   = 1'b1;
                    write_d      = 1'b1;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                timer_dec = (timer_val != '0);
                // Timer at zero marks the last of the SRAM_WAIT hold cycles.
                if (timer_zero) begin
                    write_d = 1'b0;
                    if (remaining_q == ADDR_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                        address_d   = address_q + 1'b1;
                        state_d     = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            address_q    <= '0;
            remaining_q  <= '0;
            write_data_q <= '0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            remaining_q  <= remaining_d;
            write_data_q <= write_data_d;
            write_q      <= write_d;
            done_q       <= done_d;
        end
    end

    assign wready     = (state_q == WAIT_DATA);
    assign busy       = (state_q != IDLE);
    assign address    = address_q;
    assign write_data = write_data_q;
    assign write      = write_q;
    assign done       = done_q;

endmodule
